// File: rtl/unified_cache_mem_responder_pkg.sv
// Shared packet layout and FSM state encoding for the unified cache memory responder.
// The cache bank uses the same field positions, so change them here only.
package unified_cache_mem_responder_pkg;

  localparam int unsigned UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES  = 16;

  // Packet layout, LSB first: line data, byte address, valid, critical, request id.
  localparam int unsigned UNIFIED_CACHE_PACKET_DATA_POS_LO   = 0;
  localparam int unsigned UNIFIED_CACHE_PACKET_DATA_POS_HI   = UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES * 8 - 1;
  localparam int unsigned UNIFIED_CACHE_PACKET_ADDR_POS_LO   = UNIFIED_CACHE_PACKET_DATA_POS_HI + 1;
  localparam int unsigned UNIFIED_CACHE_PACKET_ADDR_POS_HI   = UNIFIED_CACHE_PACKET_ADDR_POS_LO + 31;
  localparam int unsigned UNIFIED_CACHE_PACKET_VALID_POS     = UNIFIED_CACHE_PACKET_ADDR_POS_HI + 1;
  localparam int unsigned UNIFIED_CACHE_PACKET_CRITICAL_POS  = UNIFIED_CACHE_PACKET_VALID_POS + 1;
  localparam int unsigned UNIFIED_CACHE_PACKET_ID_POS_LO     = UNIFIED_CACHE_PACKET_CRITICAL_POS + 1;
  localparam int unsigned UNIFIED_CACHE_PACKET_ID_POS_HI     = UNIFIED_CACHE_PACKET_ID_POS_LO + 7;
  localparam int unsigned UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = UNIFIED_CACHE_PACKET_ID_POS_HI + 1;

  typedef enum logic [2:0] {
    IDLE,
    WB_ACK,
    MISS_ACK,
    WAIT,
    RESPOND
  } responder_state_e;

endpackage

// File: rtl/unified_cache_mem_array.sv
// Line-granular behavioural store: single port, synchronous write, asynchronous read.
// Deliberately has no reset so contents survive a responder reset.
module unified_cache_mem_array #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned BLOCK_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         write_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] index,
  input  logic [BLOCK_SIZE*8-1:0]      write_line,
  output logic [BLOCK_SIZE*8-1:0]      read_line
);

  logic [BLOCK_SIZE*8-1:0] lines [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      lines[index] <= write_line;
    end
  end

  assign read_line = lines[index];

endmodule

// File: rtl/unified_cache_mem_responder.sv
// Memory-side responder for the unified cache bank: serves one miss or writeback at a time
// and returns filled miss packets after a fixed latency on the fetched-request channel.
module unified_cache_mem_responder
  import unified_cache_mem_responder_pkg::*;
#(
  parameter int unsigned PACKET_WIDTH = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int unsigned BLOCK_SIZE   = UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned MEM_LATENCY  = 4
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [PACKET_WIDTH-1:0] miss_request_in,
  input  logic                    miss_request_valid_in,
  input  logic                    miss_request_critical_in,
  output logic                    miss_request_ack_out,
  input  logic [PACKET_WIDTH-1:0] writeback_request_in,
  input  logic                    writeback_request_valid_in,
  input  logic                    writeback_request_critical_in,
  output logic                    writeback_request_ack_out,
  output logic [PACKET_WIDTH-1:0] fetched_request_out,
  output logic                    fetched_request_valid_out,
  input  logic                    fetch_ack_in,
  output logic                    busy_out
);

  localparam int unsigned OFFSET_BITS = $clog2(BLOCK_SIZE);
  localparam int unsigned INDEX_BITS  = $clog2(MEM_DEPTH);
  localparam int unsigned LINE_BITS   = BLOCK_SIZE * 8;
  localparam int unsigned INDEX_LO    = UNIFIED_CACHE_PACKET_ADDR_POS_LO + OFFSET_BITS;

  responder_state_e        state;
  responder_state_e        next_state;
  logic [PACKET_WIDTH-1:0] req_packet;
  logic [INDEX_BITS-1:0]   req_index;
  logic [7:0]              latency_count;
  logic [LINE_BITS-1:0]    line_data;
  logic [INDEX_BITS-1:0]   miss_index;
  logic [INDEX_BITS-1:0]   wb_index;
  logic                    miss_wins;
  logic                    take_wb;
  logic                    take_miss;

  assign miss_index = miss_request_in[INDEX_LO +: INDEX_BITS];
  assign wb_index   = writeback_request_in[INDEX_LO +: INDEX_BITS];

  // Writeback goes first unless a critical miss can safely overtake it (different line).
  assign miss_wins = miss_request_valid_in && miss_request_critical_in &&
                     !writeback_request_critical_in && (miss_index != wb_index);
  assign take_wb   = writeback_request_valid_in && !miss_wins;
  assign take_miss = miss_request_valid_in && !take_wb;

  unified_cache_mem_array #(
    .MEM_DEPTH  (MEM_DEPTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) mem_array (
    .clk        (clk_in),
    .write_en   (state == WB_ACK),
    .index      (req_index),
    .write_line (req_packet[UNIFIED_CACHE_PACKET_DATA_POS_LO +: LINE_BITS]),
    .read_line  (line_data)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= IDLE;
      latency_count <= '0;
      req_packet    <= '0;
      req_index     <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (take_wb) begin
            req_packet <= writeback_request_in;
            req_index  <= wb_index;
          end else if (take_miss) begin
            req_packet <= miss_request_in;
            req_index  <= miss_index;
          end
        end
        MISS_ACK: latency_count <= 8'(MEM_LATENCY - 1);
        WAIT:     latency_count <= latency_count - 8'd1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    next_state                = state;
    miss_request_ack_out      = 1'b0;
    writeback_request_ack_out = 1'b0;
    fetched_request_valid_out = 1'b0;
    fetched_request_out       = '0;
    busy_out                  = (state != IDLE);
    case (state)
      IDLE: begin
        if (take_wb) begin
          next_state = WB_ACK;
        end else if (take_miss) begin
          next_state = MISS_ACK;
        end
      end
      WB_ACK: begin
        writeback_request_ack_out = 1'b1;
        next_state                = IDLE;
      end
      MISS_ACK: begin
        miss_request_ack_out = 1'b1;
        next_state           = (MEM_LATENCY == 1) ? RESPOND : WAIT;
      end
      WAIT: begin
        // Leaving on count 1 lands RESPOND exactly MEM_LATENCY cycles after the ack.
        if (latency_count <= 8'd1) begin
          next_state = RESPOND;
        end
      end
      RESPOND: begin
        fetched_request_valid_out = 1'b1;
        fetched_request_out       = req_packet;
        fetched_request_out[UNIFIED_CACHE_PACKET_DATA_POS_LO +: LINE_BITS] = line_data;
        fetched_request_out[UNIFIED_CACHE_PACKET_VALID_POS] = 1'b1;
        if (fetch_ack_in) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_unified_cache_mem_responder.sv
// Directed bench for unified_cache_mem_responder with hand-computed expected packets.
module tb_unified_cache_mem_responder;
  import unified_cache_mem_responder_pkg::*;

  localparam int unsigned PW      = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int unsigned LATENCY = 4;

  logic          clk;
  logic          reset;
  logic [PW-1:0] miss_pkt;
  logic          miss_valid;
  logic          miss_crit;
  logic          miss_ack;
  logic [PW-1:0] wb_pkt;
  logic          wb_valid;
  logic          wb_crit;
  logic          wb_ack;
  logic [PW-1:0] fetched_pkt;
  logic          fetched_valid;
  logic          fetch_ack;
  logic          busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned wb_ack_count = 0;

  unified_cache_mem_responder #(
    .PACKET_WIDTH (PW),
    .BLOCK_SIZE   (16),
    .MEM_DEPTH    (256),
    .MEM_LATENCY  (LATENCY)
  ) dut (
    .clk_in                        (clk),
    .reset_in                      (reset),
    .miss_request_in               (miss_pkt),
    .miss_request_valid_in         (miss_valid),
    .miss_request_critical_in      (miss_crit),
    .miss_request_ack_out          (miss_ack),
    .writeback_request_in          (wb_pkt),
    .writeback_request_valid_in    (wb_valid),
    .writeback_request_critical_in (wb_crit),
    .writeback_request_ack_out     (wb_ack),
    .fetched_request_out           (fetched_pkt),
    .fetched_request_valid_out     (fetched_valid),
    .fetch_ack_in                  (fetch_ack),
    .busy_out                      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (wb_ack) wb_ack_count <= wb_ack_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] make_pkt(input int unsigned line, input logic [127:0] data,
                                             input logic [7:0] id);
    logic [PW-1:0] p;
    p = '0;
    p[UNIFIED_CACHE_PACKET_DATA_POS_LO +: 128] = data;
    p[UNIFIED_CACHE_PACKET_ADDR_POS_LO +: 32]  = 32'(line) << 4;
    p[UNIFIED_CACHE_PACKET_ID_POS_LO +: 8]     = id;
    return p;
  endfunction

  function automatic logic [PW-1:0] exp_resp(input logic [PW-1:0] req, input logic [127:0] data);
    logic [PW-1:0] p;
    p = req;
    p[UNIFIED_CACHE_PACKET_DATA_POS_LO +: 128] = data;
    p[UNIFIED_CACHE_PACKET_VALID_POS] = 1'b1;
    return p;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic do_wb(input logic [PW-1:0] pkt, input logic crit);
    int n;
    wb_pkt = pkt; wb_valid = 1'b1; wb_crit = crit; n = 0;
    do begin @(negedge clk); n++; end while (!wb_ack && n < 20);
    check_eq("wb_ack_latency", 256'(n), 256'(1));
    wb_valid = 1'b0; wb_crit = 1'b0;
    @(negedge clk);
    check_eq("wb_ack_pulse", 256'(wb_ack), 256'(0));
  endtask

  task automatic wait_response(input logic [PW-1:0] exp, input int hold);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) check_eq("miss_ack_pulse", 256'(miss_ack), 256'(0));
    end while (!fetched_valid && n < 40);
    check_eq("resp_latency", 256'(n), 256'(LATENCY));
    check_eq("resp_pkt", 256'(fetched_pkt), 256'(exp));
    check_eq("resp_busy", 256'(busy), 256'(1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 256'(fetched_valid), 256'(1));
      check_eq("hold_pkt", 256'(fetched_pkt), 256'(exp));
    end
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    check_eq("resp_valid_drop", 256'(fetched_valid), 256'(0));
    check_eq("resp_idle", 256'(busy), 256'(0));
  endtask

  task automatic do_miss(input logic [PW-1:0] pkt, input logic crit, input logic [127:0] data,
                         input int hold);
    int n;
    miss_pkt = pkt; miss_valid = 1'b1; miss_crit = crit; n = 0;
    do begin @(negedge clk); n++; end while (!miss_ack && n < 20);
    check_eq("miss_ack_latency", 256'(n), 256'(1));
    miss_valid = 1'b0; miss_crit = 1'b0;
    wait_response(exp_resp(pkt, data), hold);
  endtask

  initial begin
    logic [127:0] d_a5, d_1234, d9, d10, d11, d12;
    logic [PW-1:0] p;
    int n, wb_before;
    d_a5   = {16{8'hA5}};
    d_1234 = {8{16'h1234}};
    d9     = {4{32'h9999_0001}};
    d10    = {4{32'h1010_CAFE}};
    d11    = {4{32'h1111_BEEF}};
    d12    = {4{32'h1212_F00D}};

    reset = 1'b1; miss_valid = 1'b0; miss_crit = 1'b0; miss_pkt = '0;
    wb_valid = 1'b0; wb_crit = 1'b0; wb_pkt = '0; fetch_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_miss_ack", 256'(miss_ack), 256'(0));
    check_eq("rst_wb_ack", 256'(wb_ack), 256'(0));
    check_eq("rst_valid", 256'(fetched_valid), 256'(0));
    check_eq("rst_busy", 256'(busy), 256'(0));
    check_eq("rst_pkt", 256'(fetched_pkt), 256'(0));
    reset = 1'b0;
    @(negedge clk);

    // Preload line 5, then a plain miss with the packet valid bit clear on input.
    do_wb(make_pkt(5, d_a5, 8'h01), 1'b0);
    do_miss(make_pkt(5, '0, 8'h02), 1'b0, d_a5, 0);

    do_wb(make_pkt(7, d_1234, 8'h03), 1'b0);
    do_miss(make_pkt(7, {4{32'hDEAD_0000}}, 8'h04), 1'b0, d_1234, 0);

    // Same line, miss critical: writeback must still go first.
    wb_pkt = make_pkt(9, d9, 8'h05); wb_valid = 1'b1; wb_crit = 1'b0;
    p = make_pkt(9, '0, 8'h06);
    miss_pkt = p; miss_valid = 1'b1; miss_crit = 1'b1;
    @(negedge clk);
    check_eq("same_wb_ack", 256'(wb_ack), 256'(1));
    check_eq("same_miss_noack", 256'(miss_ack), 256'(0));
    wb_valid = 1'b0;
    @(negedge clk);
    check_eq("same_idle_noack", 256'(miss_ack), 256'(0));
    @(negedge clk);
    check_eq("same_miss_ack", 256'(miss_ack), 256'(1));
    miss_valid = 1'b0; miss_crit = 1'b0;
    wait_response(exp_resp(p, d9), 0);

    // Different lines, critical miss overtakes a non-critical writeback.
    do_wb(make_pkt(10, d10, 8'h07), 1'b0);
    wb_before = wb_ack_count;
    wb_pkt = make_pkt(11, d11, 8'h08); wb_valid = 1'b1; wb_crit = 1'b0;
    p = make_pkt(10, '0, 8'h09);
    miss_pkt = p; miss_valid = 1'b1; miss_crit = 1'b1;
    @(negedge clk);
    check_eq("diff_miss_ack", 256'(miss_ack), 256'(1));
    check_eq("diff_wb_noack", 256'(wb_ack), 256'(0));
    miss_valid = 1'b0; miss_crit = 1'b0;
    wait_response(exp_resp(p, d10), 0);
    check_eq("diff_wb_held", 256'(wb_ack_count - wb_before), 256'(0));
    @(negedge clk);
    check_eq("diff_wb_ack", 256'(wb_ack), 256'(1));
    wb_valid = 1'b0;
    @(negedge clk);
    check_eq("diff_wb_count", 256'(wb_ack_count - wb_before), 256'(1));
    do_miss(make_pkt(11, '0, 8'h0A), 1'b0, d11, 0);

    // Response held for 10 extra cycles; line 5 reached through a wrapped address.
    do_miss(make_pkt(5 + 256, '0, 8'h0B), 1'b0, d_a5, 10);
    do_miss(make_pkt(7, '0, 8'h0C), 1'b1, d_1234, 0);

    // Reset during WAIT aborts the miss but leaves the store intact.
    do_wb(make_pkt(12, d12, 8'h0D), 1'b0);
    miss_pkt = make_pkt(12, '0, 8'h0E); miss_valid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!miss_ack && n < 20);
    check_eq("rstw_miss_ack", 256'(n), 256'(1));
    miss_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rstw_busy_before", 256'(busy), 256'(1));
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstw_busy", 256'(busy), 256'(0));
    check_eq("rstw_valid", 256'(fetched_valid), 256'(0));
    reset = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (fetched_valid) n++;
    end
    check_eq("rstw_no_resp", 256'(n), 256'(0));
    do_miss(make_pkt(12, '0, 8'h0F), 1'b0, d12, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
